keypad_entry_ctrl: RTL

Sequencing controller that sits directly behind the `keypad` scanner and turns its stream of decoded key presses into complete multi-digit numeric commands. Digits are accumulated into a packed-BCD entry buffer, with '*' acting as backspace and '#' as commit. A committed entry is presented to downstream configuration logic (port number, VLAN ID, PIN) over a valid/ready handshake. An inactivity timer discards abandoned entries.

---
 rtl/keypad_entry_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Turns decoded key presses from the keypad scanner into multi-digit
// packed-BCD commands. '*' deletes the newest digit and '#' commits the entry.
// A committed entry is offered downstream over a valid/ready handshake.
// An inactivity timer discards entries that are left unfinished.
module keypad_entry_ctrl #(
    parameter int  MAX_DIGITS     = 4,
    parameter int  TIMEOUT_CYCLES = 1_000_000,
    localparam int LW             = $clog2(MAX_DIGITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    output logic [4*MAX_DIGITS-1:0]   entry_value,
    output logic [LW-1:0]             entry_len,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [4*MAX_DIGITS-1:0]   cmd_value,
    output logic [LW-1:0]             cmd_len,
    output logic                      busy,
    output logic                      err
);

    localparam int DW = 4 * MAX_DIGITS;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]    state_reg,       state_next;
    logic [DW-1:0] entry_value_reg, entry_value_next;
    logic [LW-1:0] entry_len_reg,   entry_len_next;
    logic          cmd_valid_reg,   cmd_valid_next;
    logic [DW-1:0] cmd_value_reg,   cmd_value_next;
    logic [LW-1:0] cmd_len_reg,     cmd_len_next;
    logic [TW-1:0] timer_reg,       timer_next;
    logic          busy_reg,        busy_next;
    logic          err_reg,         err_next;

    logic key_digit;
    logic key_star;
    logic key_hash;
    logic key_any;

    // Classify the incoming key; codes 12..15 match nothing and are ignored
    always_comb begin
        key_digit = key_valid && (key_code <= 4'd9);
        key_star  = key_valid && (key_code == 4'd10);
        key_hash  = key_valid && (key_code == 4'd11);
        key_any   = key_valid && (key_code <= 4'd11);
    end

    // Next-state and datapath: one key (or one timeout) handled per cycle
    always_comb begin
        state_next       = state_reg;
        entry_value_next = entry_value_reg;
        entry_len_next   = entry_len_reg;
        cmd_valid_next   = cmd_valid_reg;
        cmd_value_next   = cmd_value_reg;
        cmd_len_next     = cmd_len_reg;
        timer_next       = '0;
        err_next         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // '*' and '#' on an empty entry do nothing
                if (key_digit) begin
                    entry_value_next = DW'(key_code);
                    entry_len_next   = LW'(1);
                    state_next       = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (key_any) begin
                    // Any recognised key, even a dropped overflow digit,
                    // counts as activity; a key also beats a timeout.
                    if (key_digit) begin
                        if (entry_len_reg == LW'(MAX_DIGITS)) begin
                            err_next = 1'b1;
                        end else begin
                            entry_value_next = (entry_value_reg << 4) | DW'(key_code);
                            entry_len_next   = entry_len_reg + LW'(1);
                        end
                    end else if (key_star) begin
                        entry_value_next = entry_value_reg >> 4;
                        entry_len_next   = entry_len_reg - LW'(1);
                        if (entry_len_reg == LW'(1)) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cmd_value_next = entry_value_reg;
                        cmd_len_next   = entry_len_reg;
                        cmd_valid_next = 1'b1;
                        state_next     = ST_COMMIT;
                    end
                end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    entry_value_next = '0;
                    entry_len_next   = '0;
                    err_next         = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_COMMIT: begin
                // Keys are swallowed here; only the handshake moves us on
                if (cmd_valid_reg && cmd_ready) begin
                    cmd_valid_next   = 1'b0;
                    entry_value_next = '0;
                    entry_len_next   = '0;
                    state_next       = ST_IDLE;
                end
            end

            default: begin
                entry_value_next = '0;
                entry_len_next   = '0;
                cmd_valid_next   = 1'b0;
                state_next       = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers; active-low reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            entry_value_reg <= '0;
            entry_len_reg   <= '0;
            cmd_valid_reg   <= 1'b0;
            cmd_value_reg   <= '0;
            cmd_len_reg     <= '0;
            timer_reg       <= '0;
            busy_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            entry_value_reg <= entry_value_next;
            entry_len_reg   <= entry_len_next;
            cmd_valid_reg   <= cmd_valid_next;
            cmd_value_reg   <= cmd_value_next;
            cmd_len_reg     <= cmd_len_next;
            timer_reg       <= timer_next;
            busy_reg        <= busy_next;
            err_reg         <= err_next;
        end
    end

    assign entry_value = entry_value_reg;
    assign entry_len   = entry_len_reg;
    assign cmd_valid   = cmd_valid_reg;
    assign cmd_value   = cmd_value_reg;
    assign cmd_len     = cmd_len_reg;
    assign busy        = busy_reg;
    assign err         = err_reg;

endmodule
